// File: rtl/pipeline_ctrl_pkg.sv
// Shared stage indices, forwarding encoding and per-cycle control modes
// for the pipeline sequencing and hazard unit.
package pipeline_ctrl_pkg;
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int FWD_RF  = 0;

  typedef enum logic [2:0] {
    MODE_HOLD,
    MODE_RUN,
    MODE_MEM,
    MODE_FLUSH,
    MODE_LDUSE
  } mode_e;
endpackage

// File: rtl/pipeline_ctrl_fwd_select.sv
// Priority-encodes the youngest in-flight writer of one EXE source register.
// Purely combinational; 0 selects the register file.
module fwd_select
  import pipeline_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int AW     = 5,
  parameter int FW     = 2
) (
  input  logic [AW-1:0]             src_i,
  input  logic                      used_i,
  input  logic [NSTAGE-1:3]         valid_i,
  input  logic [NSTAGE-1:3]         wen_i,
  input  logic [NSTAGE-1:3][AW-1:0] dest_i,
  output logic [FW-1:0]             sel_o
);

  always_comb begin
    sel_o = FW'(FWD_RF);
    // Scan oldest to youngest so the lowest matching stage wins.
    if (used_i && (src_i != '0)) begin
      for (int s = NSTAGE - 1; s >= 3; s--) begin
        if (valid_i[s] && wen_i[s] && (dest_i[s] == src_i)) begin
          sel_o = FW'(s - 2);
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing and hazard unit: stage enables/clears, interlocks, flushes, forwarding.
// Controls are combinational from registered stage tags; state moves only on an advance.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int AW       = 5,
  parameter int LD_READY = 4,
  parameter int BR_STAGE = 3,
  localparam int FW      = $clog2(NSTAGE - 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [AW-1:0]     id_rs_addr,
  input  logic [AW-1:0]     id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [AW-1:0]     id_dest_addr,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              branch_taken,
  input  logic              mem_stall,
  output logic [NSTAGE-1:0] stage_en,
  output logic [NSTAGE-1:0] stage_rst,
  output logic [NSTAGE-1:0] stage_valid,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic              load_use_stall,
  output logic              flush
);

  logic                      debug_step_q;
  logic [NSTAGE-1:0]         valid_q, valid_d;
  logic [NSTAGE-1:2][AW-1:0] dest_q, dest_d;
  logic [NSTAGE-1:2]         wen_q, wen_d, load_q, load_d;
  logic [AW-1:0]             rs_q, rs_d, rt_q, rt_d;
  logic                      rs_used_q, rs_used_d, rt_used_q, rt_used_d;
  logic [NSTAGE-1:2]         ld_hit;
  logic [NSTAGE-1:3]         fwd_wen;
  logic                      step_p, adv;
  mode_e                     mode;

  assign step_p = debug_step & ~debug_step_q;
  assign adv    = ~debug_en | step_p;

  always_comb begin
    if (!adv)                                  mode = MODE_HOLD;
    else if (mem_stall)                        mode = MODE_MEM;
    else if (branch_taken && valid_q[BR_STAGE]) mode = MODE_FLUSH;
    else if (|ld_hit)                          mode = MODE_LDUSE;
    else                                       mode = MODE_RUN;
  end

  always_comb begin
    stage_en  = '0;
    stage_rst = '0;
    if (rst) begin
      stage_rst = '1;
    end else begin
      case (mode)
        MODE_RUN: stage_en = '1;
        MODE_MEM: stage_rst[NSTAGE-1] = 1'b1;
        MODE_FLUSH: begin
          for (int i = 0; i < NSTAGE; i++) begin
            if (i >= 1 && i <= BR_STAGE) stage_rst[i] = 1'b1;
            else                         stage_en[i]  = 1'b1;
          end
        end
        MODE_LDUSE: begin
          stage_en           = '1;
          stage_en[STG_IF]   = 1'b0;
          stage_en[STG_ID]   = 1'b0;
          stage_en[STG_EXE]  = 1'b0;
          stage_rst[STG_EXE] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign flush          = (mode == MODE_FLUSH);
  assign load_use_stall = (mode == MODE_LDUSE);
  assign stage_valid    = valid_q;

  assign valid_d[STG_IF] = adv ? 1'b1 : valid_q[STG_IF];
  assign valid_d[STG_ID] = stage_rst[STG_ID] ? 1'b0 :
                           (stage_en[STG_ID] ? valid_q[STG_IF] : valid_q[STG_ID]);

  genvar s;
  generate
    for (s = 2; s < NSTAGE; s++) begin : g_stage
      // Only loads that cannot yet supply data to EXE force an interlock.
      if (s <= LD_READY - 2) begin : g_hz
        assign ld_hit[s] = valid_q[s] & wen_q[s] & load_q[s] & (dest_q[s] != '0) &
                           ((id_rs_used & (dest_q[s] == id_rs_addr)) |
                            (id_rt_used & (dest_q[s] == id_rt_addr)));
      end else begin : g_nohz
        assign ld_hit[s] = 1'b0;
      end

      assign valid_d[s] = stage_rst[s] ? 1'b0 : (stage_en[s] ? valid_q[s-1] : valid_q[s]);

      if (s == STG_EXE) begin : g_exe
        assign dest_d[s] = stage_en[s] ? id_dest_addr : dest_q[s];
        assign wen_d[s]  = stage_en[s] ? id_wen       : wen_q[s];
        assign load_d[s] = stage_en[s] ? id_is_load   : load_q[s];
        assign rs_d      = stage_en[s] ? id_rs_addr   : rs_q;
        assign rt_d      = stage_en[s] ? id_rt_addr   : rt_q;
        assign rs_used_d = stage_en[s] ? id_rs_used   : rs_used_q;
        assign rt_used_d = stage_en[s] ? id_rt_used   : rt_used_q;
      end else begin : g_up
        assign dest_d[s]  = stage_en[s] ? dest_q[s-1] : dest_q[s];
        assign wen_d[s]   = stage_en[s] ? wen_q[s-1]  : wen_q[s];
        assign load_d[s]  = stage_en[s] ? load_q[s-1] : load_q[s];
        assign fwd_wen[s] = wen_q[s] & ~(load_q[s] & (s < LD_READY));
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debug_step_q <= 1'b0;
      valid_q      <= '0;
      dest_q       <= '0;
      wen_q        <= '0;
      load_q       <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rs_used_q    <= 1'b0;
      rt_used_q    <= 1'b0;
    end else begin
      debug_step_q <= debug_step;
      valid_q      <= valid_d;
      dest_q       <= dest_d;
      wen_q        <= wen_d;
      load_q       <= load_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rs_used_q    <= rs_used_d;
      rt_used_q    <= rt_used_d;
    end
  end

  fwd_select #(.NSTAGE(NSTAGE), .AW(AW), .FW(FW)) u_fwd_a (
    .src_i   (rs_q),
    .used_i  (rs_used_q),
    .valid_i (valid_q[NSTAGE-1:3]),
    .wen_i   (fwd_wen),
    .dest_i  (dest_q[NSTAGE-1:3]),
    .sel_o   (fwd_a)
  );

  fwd_select #(.NSTAGE(NSTAGE), .AW(AW), .FW(FW)) u_fwd_b (
    .src_i   (rt_q),
    .used_i  (rt_used_q),
    .valid_i (valid_q[NSTAGE-1:3]),
    .wen_i   (fwd_wen),
    .dest_i  (dest_q[NSTAGE-1:3]),
    .sel_o   (fwd_b)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: four parameterisations share one stimulus stream.
// Each task drives a scenario and checks hand-computed outputs of the relevant instance.
module tb_pipeline_ctrl;
  logic       clk, rst, debug_en, debug_step;
  logic [4:0] id_rs_addr, id_rt_addr, id_dest_addr;
  logic       id_rs_used, id_rt_used, id_wen, id_is_load;
  logic       branch_taken, mem_stall;

  int errors = 0;
  int checks = 0;

  // Default: NSTAGE=5, LD_READY=4, BR_STAGE=3
  logic [4:0] d5_en, d5_rst, d5_valid;
  logic [1:0] d5_fa, d5_fb;
  logic       d5_lus, d5_fl;
  // LD_READY=3
  logic [4:0] l3_en, l3_rst, l3_valid;
  logic [1:0] l3_fa, l3_fb;
  logic       l3_lus, l3_fl;
  // NSTAGE=7
  logic [6:0] d7_en, d7_rst, d7_valid;
  logic [2:0] d7_fa, d7_fb;
  logic       d7_lus, d7_fl;
  // NSTAGE=4, LD_READY=3, BR_STAGE=2
  logic [3:0] d4_en, d4_rst, d4_valid;
  logic [1:0] d4_fa, d4_fb;
  logic       d4_lus, d4_fl;

  pipeline_ctrl u_d5 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_dest_addr(id_dest_addr), .id_wen(id_wen),
    .id_is_load(id_is_load), .branch_taken(branch_taken), .mem_stall(mem_stall),
    .stage_en(d5_en), .stage_rst(d5_rst), .stage_valid(d5_valid),
    .fwd_a(d5_fa), .fwd_b(d5_fb), .load_use_stall(d5_lus), .flush(d5_fl));

  pipeline_ctrl #(.LD_READY(3)) u_l3 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_dest_addr(id_dest_addr), .id_wen(id_wen),
    .id_is_load(id_is_load), .branch_taken(branch_taken), .mem_stall(mem_stall),
    .stage_en(l3_en), .stage_rst(l3_rst), .stage_valid(l3_valid),
    .fwd_a(l3_fa), .fwd_b(l3_fb), .load_use_stall(l3_lus), .flush(l3_fl));

  pipeline_ctrl #(.NSTAGE(7)) u_d7 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_dest_addr(id_dest_addr), .id_wen(id_wen),
    .id_is_load(id_is_load), .branch_taken(branch_taken), .mem_stall(mem_stall),
    .stage_en(d7_en), .stage_rst(d7_rst), .stage_valid(d7_valid),
    .fwd_a(d7_fa), .fwd_b(d7_fb), .load_use_stall(d7_lus), .flush(d7_fl));

  pipeline_ctrl #(.NSTAGE(4), .LD_READY(3), .BR_STAGE(2)) u_d4 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_dest_addr(id_dest_addr), .id_wen(id_wen),
    .id_is_load(id_is_load), .branch_taken(branch_taken), .mem_stall(mem_stall),
    .stage_en(d4_en), .stage_rst(d4_rst), .stage_valid(d4_valid),
    .fwd_a(d4_fa), .fwd_b(d4_fb), .load_use_stall(d4_lus), .flush(d4_fl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic ru,
                        input logic tu, input logic [4:0] d, input logic w, input logic ld);
    id_rs_addr = rs; id_rt_addr = rt; id_rs_used = ru; id_rt_used = tu;
    id_dest_addr = d; id_wen = w; id_is_load = ld;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; debug_step = 1'b0; branch_taken = 1'b0; mem_stall = 1'b0;
    nop();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; #2;
    rst = 1'b1; #1;
    checks++; if (d5_rst !== 5'b11111) begin errors++; $display("FAIL reset_rst: got %b want 11111", d5_rst); end
    checks++; if (d5_en !== 5'b00000) begin errors++; $display("FAIL reset_en: got %b want 00000", d5_en); end
    checks++; if (d5_valid !== 5'b00000) begin errors++; $display("FAIL reset_valid: got %b want 00000", d5_valid); end
    checks++; if ({d5_fa, d5_fb, d5_fl, d5_lus} !== 6'b0) begin errors++; $display("FAIL reset_misc: got fa=%0d fb=%0d fl=%b lus=%b want 0", d5_fa, d5_fb, d5_fl, d5_lus); end
  endtask

  task automatic test_fill();
    logic [4:0] exp5;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp5 = 5'((1 << i) - 1);
      checks++; if (d5_valid !== exp5) begin errors++; $display("FAIL fill_valid[%0d]: got %b want %b", i, d5_valid, exp5); end
      checks++; if ({d5_fa, d5_fb} !== 4'b0) begin errors++; $display("FAIL fill_fwd[%0d]: got %0d/%0d want 0/0", i, d5_fa, d5_fb); end
    end
    checks++; if (d5_en !== 5'b11111) begin errors++; $display("FAIL fill_en: got %b want 11111", d5_en); end
    tick();
    checks++; if (d7_valid !== 7'b0111111) begin errors++; $display("FAIL fill_valid7: got %b want 0111111", d7_valid); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    tick(); tick(); tick();
    #2 rst = 1'b1; #1;
    checks++; if (d5_valid !== 5'b00000) begin errors++; $display("FAIL midrun_valid: got %b want 00000", d5_valid); end
    checks++; if (d7_valid !== 7'b0) begin errors++; $display("FAIL midrun_valid7: got %b want 0", d7_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(); tick();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3,$1,$2
    tick();
    set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);  // sub $4,$3,$5
    #1;
    checks++; if (d5_lus !== 1'b0) begin errors++; $display("FAIL b2b_nostall: got %b want 0", d5_lus); end
    tick();
    nop(); #1;
    checks++; if (d5_fa !== 2'd1) begin errors++; $display("FAIL b2b_fa5: got %0d want 1", d5_fa); end
    checks++; if (d5_fb !== 2'd0) begin errors++; $display("FAIL b2b_fb5: got %0d want 0", d5_fb); end
    checks++; if (d7_fa !== 3'd1) begin errors++; $display("FAIL b2b_fa7: got %0d want 1", d7_fa); end
    checks++; if (d4_fa !== 2'd1) begin errors++; $display("FAIL b2b_fa4: got %0d want 1", d4_fa); end
    // Same pair separated by one nop
    do_reset();
    tick(); tick();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    nop(); #1;
    checks++; if (d5_fa !== 2'd2) begin errors++; $display("FAIL gap_fa5: got %0d want 2", d5_fa); end
    checks++; if (d7_fa !== 3'd2) begin errors++; $display("FAIL gap_fa7: got %0d want 2", d7_fa); end
    checks++; if (d4_fa !== 2'd0) begin errors++; $display("FAIL gap_fa4: got %0d want 0", d4_fa); end
  endtask

  task automatic test_load_use();
    do_reset();
    tick(); tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);  // lw $2,0($1)
    tick();
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);  // add $4,$2,$2
    #1;
    checks++; if (d5_lus !== 1'b1) begin errors++; $display("FAIL lu_stall5: got %b want 1", d5_lus); end
    checks++; if (d5_en !== 5'b11000) begin errors++; $display("FAIL lu_en5: got %b want 11000", d5_en); end
    checks++; if (d5_rst !== 5'b00100) begin errors++; $display("FAIL lu_rst5: got %b want 00100", d5_rst); end
    checks++; if (l3_lus !== 1'b0) begin errors++; $display("FAIL lu_stall_l3: got %b want 0", l3_lus); end
    checks++; if (d7_lus !== 1'b1) begin errors++; $display("FAIL lu_stall7: got %b want 1", d7_lus); end
    checks++; if (d4_lus !== 1'b0) begin errors++; $display("FAIL lu_stall4: got %b want 0", d4_lus); end
    tick(); #1;
    checks++; if (d5_valid !== 5'b01011) begin errors++; $display("FAIL lu_bubble5: got %b want 01011", d5_valid); end
    checks++; if (d5_lus !== 1'b0) begin errors++; $display("FAIL lu_once5: got %b want 0", d5_lus); end
    checks++; if ({l3_fa, l3_fb} !== {2'd1, 2'd1}) begin errors++; $display("FAIL lu_fwd_l3: got %0d/%0d want 1/1", l3_fa, l3_fb); end
    checks++; if (d4_fa !== 2'd1) begin errors++; $display("FAIL lu_fwd4: got %0d want 1", d4_fa); end
    tick();
    nop(); #1;
    checks++; if ({d5_fa, d5_fb} !== {2'd2, 2'd2}) begin errors++; $display("FAIL lu_fwd5: got %0d/%0d want 2/2", d5_fa, d5_fb); end
    checks++; if ({d7_fa, d7_fb} !== {3'd2, 3'd2}) begin errors++; $display("FAIL lu_fwd7: got %0d/%0d want 2/2", d7_fa, d7_fb); end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick(); tick();
    branch_taken = 1'b1; #1;
    checks++; if (d5_fl !== 1'b1) begin errors++; $display("FAIL br_flush: got %b want 1", d5_fl); end
    checks++; if (d5_rst !== 5'b01110) begin errors++; $display("FAIL br_rst: got %b want 01110", d5_rst); end
    checks++; if (d5_en !== 5'b10001) begin errors++; $display("FAIL br_en: got %b want 10001", d5_en); end
    tick();
    branch_taken = 1'b0; #1;
    checks++; if (d5_valid !== 5'b10001) begin errors++; $display("FAIL br_valid: got %b want 10001", d5_valid); end
  endtask

  task automatic test_branch_memstall();
    do_reset();
    tick(); tick(); tick(); tick();
    branch_taken = 1'b1; mem_stall = 1'b1; #1;
    checks++; if (d5_fl !== 1'b0) begin errors++; $display("FAIL ms_noflush: got %b want 0", d5_fl); end
    checks++; if (d5_en !== 5'b00000) begin errors++; $display("FAIL ms_en: got %b want 00000", d5_en); end
    checks++; if (d5_rst !== 5'b10000) begin errors++; $display("FAIL ms_rst: got %b want 10000", d5_rst); end
    tick(); tick(); #1;
    checks++; if (d5_valid !== 5'b01111) begin errors++; $display("FAIL ms_frozen: got %b want 01111", d5_valid); end
    mem_stall = 1'b0; #1;
    checks++; if (d5_fl !== 1'b1) begin errors++; $display("FAIL ms_lateflush: got %b want 1", d5_fl); end
    tick();
    branch_taken = 1'b0; #1;
    checks++; if (d5_valid !== 5'b10001) begin errors++; $display("FAIL ms_valid: got %b want 10001", d5_valid); end
  endtask

  task automatic test_branch_loaduse();
    do_reset();
    tick(); tick();
    tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);  // lw $2
    tick();
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);  // add $4,$2,$2
    branch_taken = 1'b1; #1;
    checks++; if (d5_fl !== 1'b1) begin errors++; $display("FAIL brlu_flush: got %b want 1", d5_fl); end
    checks++; if (d5_lus !== 1'b0) begin errors++; $display("FAIL brlu_stall: got %b want 0", d5_lus); end
    checks++; if (d5_rst !== 5'b01110) begin errors++; $display("FAIL brlu_rst: got %b want 01110", d5_rst); end
    tick();
    branch_taken = 1'b0; nop(); #1;
    checks++; if (d5_valid !== 5'b10001) begin errors++; $display("FAIL brlu_valid: got %b want 10001", d5_valid); end
  endtask

  task automatic test_debug();
    debug_en = 1'b1;
    do_reset();
    tick(); tick(); #1;
    checks++; if (d5_valid !== 5'b00000) begin errors++; $display("FAIL dbg_idle_valid: got %b want 00000", d5_valid); end
    checks++; if ({d5_en, d5_rst} !== 10'b0) begin errors++; $display("FAIL dbg_idle_ctl: got en=%b rst=%b want 0", d5_en, d5_rst); end
    for (int k = 0; k < 3; k++) begin
      debug_step = 1'b1; #1;
      checks++; if (d5_en !== 5'b11111) begin errors++; $display("FAIL dbg_step_en[%0d]: got %b want 11111", k, d5_en); end
      tick();
      debug_step = 1'b0;
      tick();
    end
    checks++; if (d5_valid !== 5'b00111) begin errors++; $display("FAIL dbg_3steps: got %b want 00111", d5_valid); end
    debug_step = 1'b1;
    tick(); #1;
    checks++; if (d5_en !== 5'b00000) begin errors++; $display("FAIL dbg_held_en: got %b want 00000", d5_en); end
    repeat (9) tick();
    checks++; if (d5_valid !== 5'b01111) begin errors++; $display("FAIL dbg_held_valid: got %b want 01111", d5_valid); end
    debug_step = 1'b0;
    debug_en = 1'b0;
  endtask

  task automatic test_zero_reg();
    do_reset();
    tick(); tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // lw $0
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // add $5,$0,$0
    #1;
    checks++; if (d5_lus !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", d5_lus); end
    tick();
    nop(); #1;
    checks++; if ({d5_fa, d5_fb} !== 4'b0) begin errors++; $display("FAIL zero_fwd: got %0d/%0d want 0/0", d5_fa, d5_fb); end
    checks++; if ({l3_fa, l3_fb} !== 4'b0) begin errors++; $display("FAIL zero_fwd_l3: got %0d/%0d want 0/0", l3_fa, l3_fb); end
  endtask

  initial begin
    debug_en = 1'b0; debug_step = 1'b0; branch_taken = 1'b0; mem_stall = 1'b0;
    rst = 1'b0;
    nop();
    test_reset();
    test_fill();
    test_reset_midrun();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_branch_memstall();
    test_branch_loaduse();
    test_debug();
    test_zero_reg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
